id_stage: RTL and testbench

- Instruction Decode stage of the 5-stage pipeline CPU.
- It is the consumer end of the IF/ID interface. It takes the fetched PC and instruction, and returns the PC-redirect pair (o_PCSrc, o_branch_addr) plus stall/flush controls to the fetch stage.
- Contains the 32x32 register file, main control decoder, branch/jump resolution, load-use hazard detection and the ID/EX pipeline register.

---
 rtl/id_stage_pkg.sv | 49 ++++
 rtl/id_stage_regfile.sv | 45 ++++
 rtl/id_stage.sv | 162 ++++++++++++++++
 tb/tb_id_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU classes,
// instruction field positions and the ID/EX control bundle.
package id_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 6;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // ALU class handed to EX
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Instruction field bit positions
  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 26;
  localparam int unsigned RS_HI   = 25;
  localparam int unsigned RS_LO   = 21;
  localparam int unsigned RT_HI   = 20;
  localparam int unsigned RT_LO   = 16;
  localparam int unsigned RD_HI   = 15;
  localparam int unsigned RD_LO   = 11;
  localparam int unsigned IMM_HI  = 15;
  localparam int unsigned IMM_LO  = 0;
  localparam int unsigned JIDX_HI = 25;
  localparam int unsigned JIDX_LO = 0;

  // Control bundle carried in ID/EX
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: 2**REG_AW x DATA_W, synchronous write, two asynchronous
// read ports with write-through bypass; register 0 is hardwired to zero.
// Ports: i_clk, i_rst (sync, active-high, clears all entries),
//        i_we/i_waddr/i_wdata write port, i_raddr_a/b -> o_rdata_a/b.
module id_stage_regfile
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int unsigned NREGS = 1 << REG_AW;

  logic [DATA_W-1:0] mem [NREGS];

  // Write port; writes to index 0 are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read ports with same-cycle writeback forwarding
  assign o_rdata_a = (i_raddr_a == '0)                    ? '0      :
                     (i_we && (i_waddr == i_raddr_a))     ? i_wdata :
                                                            mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0)                    ? '0      :
                     (i_we && (i_waddr == i_raddr_b))     ? i_wdata :
                                                            mem[i_raddr_b];

endmodule

// File: rtl/id_stage.sv
// Instruction Decode stage: register file, main decoder, branch/jump
// resolution in ID, load-use / branch-dependency stall, ID/EX register.
// Inputs : IF/ID pc+instruction, writeback port, EX-stage hazard info.
// Outputs: combinational redirect/stall/flush to fetch; registered ID/EX
//          operands, immediate, register indices and controls.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_next_pc,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_reg_write,
  input  logic [REG_AW-1:0] i_ex_dst,
  output logic              o_PCSrc,
  output logic [DATA_W-1:0] o_branch_addr,
  output logic              o_stall,
  output logic              o_if_flush,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_imm,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_alu_src,
  output logic              o_reg_dst,
  output logic [1:0]        o_alu_op
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic [DATA_W-1:0] pc_plus4, br_target, j_target;
  logic              is_beq, is_bne, is_j;
  logic              ex_hit, stall, taken, redirect;
  ctrl_t             ctrl;
  ctrl_t             id_ex_ctrl;

  assign opcode = i_data[OPC_HI:OPC_LO];
  assign rs     = REG_AW'(i_data[RS_HI:RS_LO]);
  assign rt     = REG_AW'(i_data[RT_HI:RT_LO]);
  assign rd     = REG_AW'(i_data[RD_HI:RD_LO]);
  assign imm    = DATA_W'($signed(i_data[IMM_HI:IMM_LO]));

  id_stage_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_wb_we),
    .i_waddr  (i_wb_addr),
    .i_wdata  (i_wb_data),
    .i_raddr_a(rs),
    .i_raddr_b(rt),
    .o_rdata_a(rs_data),
    .o_rdata_b(rt_data)
  );

  // Main control decoder; unknown opcodes decode as NOP
  always_comb begin
    ctrl   = CTRL_NOP;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        is_beq      = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        is_bne      = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J: is_j = 1'b1;
      default: ;
    endcase
  end

  // Branch/jump targets
  assign pc_plus4  = i_next_pc + DATA_W'(4);
  assign br_target = pc_plus4 + (imm << 2);
  assign j_target  = {pc_plus4[DATA_W-1:DATA_W-4], i_data[JIDX_HI:JIDX_LO], 2'b00};

  // Hazards: a pending load, or any pending write feeding a branch compare
  assign ex_hit = (i_ex_dst != '0) && ((i_ex_dst == rs) || (i_ex_dst == rt));
  assign stall  = ex_hit && (i_ex_mem_read || ((is_beq || is_bne) && i_ex_reg_write));

  // Redirect only on resolved operands
  assign taken    = (is_beq && (rs_data == rt_data)) ||
                    (is_bne && (rs_data != rt_data)) || is_j;
  assign redirect = taken && !stall;

  assign o_stall       = stall;
  assign o_PCSrc       = redirect;
  assign o_if_flush    = redirect;
  assign o_branch_addr = !redirect ? '0 : (is_j ? j_target : br_target);

  // ID/EX register: bubble on reset or stall; branches/jumps enter with no controls
  always_ff @(posedge i_clk) begin
    if (i_rst || stall) begin
      o_pc       <= '0;
      o_rs_data  <= '0;
      o_rt_data  <= '0;
      o_imm      <= '0;
      o_rs       <= '0;
      o_rt       <= '0;
      o_rd       <= '0;
      id_ex_ctrl <= CTRL_NOP;
    end else begin
      o_pc       <= i_next_pc;
      o_rs_data  <= rs_data;
      o_rt_data  <= rt_data;
      o_imm      <= imm;
      o_rs       <= rs;
      o_rt       <= rt;
      o_rd       <= rd;
      id_ex_ctrl <= (is_beq || is_bne || is_j) ? CTRL_NOP : ctrl;
    end
  end

  assign o_reg_write  = id_ex_ctrl.reg_write;
  assign o_mem_to_reg = id_ex_ctrl.mem_to_reg;
  assign o_mem_read   = id_ex_ctrl.mem_read;
  assign o_mem_write  = id_ex_ctrl.mem_write;
  assign o_alu_src    = id_ex_ctrl.alu_src;
  assign o_reg_dst    = id_ex_ctrl.reg_dst;
  assign o_alu_op     = id_ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// instruction streams compared against a behavioural decode model.
module tb_id_stage;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_next_pc;
  logic [31:0] i_data;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_read;
  logic        i_ex_reg_write;
  logic [4:0]  i_ex_dst;
  logic        o_PCSrc;
  logic [31:0] o_branch_addr;
  logic        o_stall;
  logic        o_if_flush;
  logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write, o_alu_src, o_reg_dst;
  logic [1:0]  o_alu_op;

  id_stage dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_next_pc     (i_next_pc),
    .i_data        (i_data),
    .i_wb_we       (i_wb_we),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_reg_write(i_ex_reg_write),
    .i_ex_dst      (i_ex_dst),
    .o_PCSrc       (o_PCSrc),
    .o_branch_addr (o_branch_addr),
    .o_stall       (o_stall),
    .o_if_flush    (o_if_flush),
    .o_pc          (o_pc),
    .o_rs_data     (o_rs_data),
    .o_rt_data     (o_rt_data),
    .o_imm         (o_imm),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_reg_write   (o_reg_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_alu_src     (o_alu_src),
    .o_reg_dst     (o_reg_dst),
    .o_alu_op      (o_alu_op)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mregs [32];
  logic        obs_pcsrc, obs_flush, obs_stall;
  logic [31:0] obs_baddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural register read as seen during a cycle with the given writeback
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  // Expected controls {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op}
  function automatic logic [7:0] model_ctrl(input logic [5:0] opc);
    case (opc)
      6'h00:   return 8'b1_0_0_0_0_1_10;
      6'h23:   return 8'b1_1_1_0_1_0_00;
      6'h2B:   return 8'b0_0_0_1_1_0_00;
      6'h08:   return 8'b1_0_0_0_1_0_00;
      default: return 8'b0;
    endcase
  endfunction

  // One clock cycle: drive, check fetch-side outputs, clock, check ID/EX
  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic exmr, input logic exrw, input logic [4:0] exd);
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, imm, pc4, tgt;
    logic        is_br, is_jmp, dep, stall_e, taken, redir;
    logic [7:0]  ctl_e, ctl_o;
    i_rst = rst; i_next_pc = pc; i_data = instr;
    i_wb_we = we; i_wb_addr = wa; i_wb_data = wd;
    i_ex_mem_read = exmr; i_ex_reg_write = exrw; i_ex_dst = exd;
    #2;
    opc = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    imm = {{16{instr[15]}}, instr[15:0]};
    rsv = model_read(rs, we, wa, wd);
    rtv = model_read(rt, we, wa, wd);
    is_br  = (opc == 6'h04) || (opc == 6'h05);
    is_jmp = (opc == 6'h02);
    dep     = (exd != 5'd0) && (exd == rs || exd == rt);
    stall_e = dep && (exmr || (is_br && exrw));
    taken   = (opc == 6'h04 && rsv == rtv) || (opc == 6'h05 && rsv != rtv) || is_jmp;
    redir   = taken && !stall_e;
    pc4 = pc + 32'd4;
    if (is_jmp) tgt = (pc4 & 32'hF000_0000) | ({6'd0, instr[25:0]} << 2);
    else        tgt = pc4 + imm * 32'd4;
    check("stall", 32'(o_stall), 32'(stall_e));
    check("pcsrc", 32'(o_PCSrc), 32'(redir));
    check("if_flush", 32'(o_if_flush), 32'(redir));
    check("branch_addr", o_branch_addr, redir ? tgt : 32'd0);
    obs_pcsrc = o_PCSrc; obs_flush = o_if_flush; obs_stall = o_stall; obs_baddr = o_branch_addr;
    @(posedge i_clk);
    #1;
    ctl_o = {o_reg_write, o_mem_to_reg, o_mem_read, o_mem_write, o_alu_src, o_reg_dst, o_alu_op};
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      check("rst_ctrl", 32'(ctl_o), 32'd0);
      check("rst_pc", o_pc, 32'd0);
      check("rst_rs_data", o_rs_data, 32'd0);
      check("rst_rt_data", o_rt_data, 32'd0);
      check("rst_imm", o_imm, 32'd0);
      check("rst_idx", 32'({o_rs, o_rt, o_rd}), 32'd0);
    end else begin
      if (we && wa != 5'd0) mregs[wa] = wd;
      ctl_e = (stall_e || is_br || is_jmp) ? 8'd0 : model_ctrl(opc);
      check("ctrl", 32'(ctl_o), 32'(ctl_e));
      if (!stall_e) begin
        check("pc", o_pc, pc);
        check("rs_data", o_rs_data, rsv);
        check("rt_data", o_rt_data, rtv);
        check("imm", o_imm, imm);
        check("idx", 32'({o_rs, o_rt, o_rd}), 32'({rs, rt, rd}));
      end
    end
  endtask

  // Writeback-only cycle with a harmless unknown-opcode instruction in ID
  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 32'h0, 32'hFC00_0000, 1'b1, wa, wd, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'hx;
    // Reset
    step(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);

    // add $3,$5,$0 after writing $5
    wb(5'd5, 32'h1234);
    step(1'b0, 32'h40, 32'h00A0_1820, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    check("tp_add_rs_data", o_rs_data, 32'h1234);
    check("tp_add_rd", 32'(o_rd), 32'd3);
    check("tp_add_reg_write", 32'(o_reg_write), 32'd1);
    check("tp_add_alu_op", 32'(o_alu_op), 32'd2);

    // sw $7,8($0) with same-cycle writeback of $7
    step(1'b0, 32'h44, 32'hAC07_0008, 1'b1, 5'd7, 32'hAAAA, 1'b0, 1'b0, 5'd0);
    check("tp_sw_rt_data", o_rt_data, 32'hAAAA);
    check("tp_sw_imm", o_imm, 32'd8);
    check("tp_sw_mem_write", 32'(o_mem_write), 32'd1);

    // beq $1,$2,-2 taken, then not taken
    wb(5'd1, 32'd9);
    wb(5'd2, 32'd9);
    step(1'b0, 32'h100, 32'h1022_FFFE, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    check("tp_beq_pcsrc", 32'(obs_pcsrc), 32'd1);
    check("tp_beq_target", obs_baddr, 32'hFC);
    check("tp_beq_flush", 32'(obs_flush), 32'd1);
    check("tp_beq_bubble", 32'({o_reg_write, o_mem_write, o_mem_read, o_alu_op}), 32'd0);
    wb(5'd2, 32'd8);
    step(1'b0, 32'h100, 32'h1022_FFFE, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    check("tp_beq_nt_pcsrc", 32'(obs_pcsrc), 32'd0);

    // Branch depending on an in-flight ALU result stalls
    step(1'b0, 32'h100, 32'h1022_FFFE, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2);
    check("tp_brdep_stall", 32'(obs_stall), 32'd1);

    // Load-use stall then normal issue
    step(1'b0, 32'h200, 32'h0084_3020, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd4);
    check("tp_lu_stall", 32'(obs_stall), 32'd1);
    check("tp_lu_bubble", 32'(o_reg_write), 32'd0);
    step(1'b0, 32'h200, 32'h0084_3020, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd4);
    check("tp_lu_issue_stall", 32'(obs_stall), 32'd0);
    check("tp_lu_issue_rw", 32'(o_reg_write), 32'd1);

    // Jump target, writeback to $0 ignored
    step(1'b0, 32'h3000_0000, 32'h0800_0040, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 5'd0);
    check("tp_j_pcsrc", 32'(obs_pcsrc), 32'd1);
    check("tp_j_target", obs_baddr, 32'h3000_0100);
    step(1'b0, 32'h50, 32'h0000_1820, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    check("tp_r0_zero", o_rs_data, 32'd0);

    // Reset mid-stream clears ID/EX and the register file
    wb(5'd5, 32'h5555);
    step(1'b0, 32'h60, 32'h00A0_1820, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h64, 32'h00A0_1820, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    check("tp_rst_rw", 32'(o_reg_write), 32'd0);
    step(1'b0, 32'h68, 32'h00A0_1820, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    check("tp_rst_r5", o_rs_data, 32'd0);

    // Randomized stream
    for (int n = 0; n < 600; n++) begin
      logic [5:0]  opc;
      logic [31:0] instr, wd;
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: opc = 6'h00;
        1: opc = 6'h23;
        2: opc = 6'h2B;
        3: opc = 6'h08;
        4: opc = 6'h04;
        5: opc = 6'h05;
        6: opc = 6'h02;
        default: opc = 6'($urandom);
      endcase
      instr = {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      wd = ($urandom_range(0, 3) < 2) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      step(($urandom_range(0, 49) == 0), {30'($urandom), 2'b00}, instr,
           1'($urandom), 5'($urandom_range(0, 7)), wd,
           ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
